// File: rtl/acc_conv_ctrl.sv
// Sequencing controller for the KxK-kernel / IMG_DIM x IMG_DIM-image convolution accelerator.
// Decodes APB register writes, sequences the A and X loads, and walks every output pixel and
// kernel tap. Pad flags are computed for the MAC datapath and results are handed back through
// an auto-incrementing read pointer.
module acc_conv_ctrl #(
    parameter int unsigned IMG_DIM = 28,
    parameter int unsigned K       = 3,
    localparam int unsigned NTAP   = K * K,
    localparam int unsigned NPIX   = IMG_DIM * IMG_DIM,
    localparam int unsigned AW     = $clog2(NTAP),
    localparam int unsigned XW     = $clog2(NPIX)
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          wr_valid,
    input  logic          rd_valid,
    input  logic [12:0]   addr,
    input  logic [31:0]   wdata,
    output logic          ready,
    output logic          clk_en,
    output logic          a_we,
    output logic          x_we,
    output logic [AW-1:0] a_waddr,
    output logic [XW-1:0] x_waddr,
    output logic [7:0]    ld_data,
    output logic [AW-1:0] a_raddr,
    output logic [XW-1:0] x_raddr,
    output logic          mac_valid,
    output logic          mac_first,
    output logic          mac_last,
    output logic          mac_pad,
    output logic [XW-1:0] res_waddr,
    output logic [XW-1:0] res_raddr,
    output logic          finish,
    output logic          err
);

    localparam int unsigned CW = $clog2(IMG_DIM);
    localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [2:0] {StIdle, StLoadA, StLoadX, StRun, StDrain, StDone} state_e;

    state_e        r_state;
    logic [AW-1:0] r_a_cnt;
    logic [XW-1:0] r_x_cnt;
    logic [CW-1:0] r_row, r_col;
    logic [KW-1:0] r_kr, r_kc;
    logic          r_mac_valid, r_mac_first, r_mac_last, r_mac_pad;
    logic [XW-1:0] r_res_waddr, r_res_raddr;
    logic          r_finish, r_err;

    logic          w_stall, w_wr, w_en_on, w_en_off, w_wr_a, w_wr_x, w_rd_res;
    logic          w_a_we, w_x_we, w_bad;
    logic          w_tap_first, w_tap_last, w_pix_last, w_run;
    logic          w_pad;
    int            w_sr, w_sc;
    logic [AW-1:0] w_a_idx;
    logic [XW-1:0] w_x_idx;
    logic          w_unused;

    // Register decode; load writes are held off while the array is still being walked
    always_comb begin
        w_run    = (r_state == StRun);
        w_stall  = wr_valid && ((addr == 13'd1) || (addr == 13'd2)) &&
                   ((r_state == StRun) || (r_state == StDrain));
        w_wr     = wr_valid && !w_stall;
        w_en_on  = w_wr && (addr == 13'd0) && wdata[0];
        w_en_off = w_wr && (addr == 13'd0) && !wdata[0];
        w_wr_a   = w_wr && (addr == 13'd1);
        w_wr_x   = w_wr && (addr == 13'd2);
        w_rd_res = rd_valid && (addr == 13'd3);
        w_a_we   = w_wr_a && ((r_state == StLoadA) || (r_state == StDone));
        w_x_we   = w_wr_x && (r_state == StLoadX);
        w_bad    = (w_wr_a && ((r_state == StIdle) || (r_state == StLoadX))) ||
                   (w_wr_x && ((r_state == StIdle) || (r_state == StLoadA)));
    end

    // Tap geometry: source pixel of the current tap and whether it falls in the zero padding
    always_comb begin
        w_tap_first = (r_kr == '0) && (r_kc == '0);
        w_tap_last  = (r_kr == KW'(K - 1)) && (r_kc == KW'(K - 1));
        w_pix_last  = (r_row == CW'(IMG_DIM - 1)) && (r_col == CW'(IMG_DIM - 1));
        w_sr        = int'(r_row) + int'(r_kr) - int'(K / 2);
        w_sc        = int'(r_col) + int'(r_kc) - int'(K / 2);
        w_pad       = (w_sr < 0) || (w_sr >= int'(IMG_DIM)) ||
                      (w_sc < 0) || (w_sc >= int'(IMG_DIM));
        w_a_idx     = AW'(int'(r_kr) * int'(K) + int'(r_kc));
        w_x_idx     = w_pad ? '0 : XW'(w_sr * int'(IMG_DIM) + w_sc);
    end

    // Controller state, counters and registered datapath qualifiers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= StIdle;
            r_a_cnt     <= '0;
            r_x_cnt     <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_kr        <= '0;
            r_kc        <= '0;
            r_mac_valid <= 1'b0;
            r_mac_first <= 1'b0;
            r_mac_last  <= 1'b0;
            r_mac_pad   <= 1'b0;
            r_res_waddr <= '0;
            r_res_raddr <= '0;
            r_finish    <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_en_off) begin
            // Abort from any state: everything back to its idle value
            r_state     <= StIdle;
            r_a_cnt     <= '0;
            r_x_cnt     <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_kr        <= '0;
            r_kc        <= '0;
            r_mac_valid <= 1'b0;
            r_mac_first <= 1'b0;
            r_mac_last  <= 1'b0;
            r_mac_pad   <= 1'b0;
            r_res_waddr <= '0;
            r_res_raddr <= '0;
            r_finish    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // Qualifiers trail the issued address by one cycle to line up with memory read data
            r_mac_valid <= w_run;
            r_mac_first <= w_run && w_tap_first;
            r_mac_last  <= w_run && w_tap_last;
            r_mac_pad   <= w_run && w_pad;
            if (w_run) begin
                r_res_waddr <= XW'(int'(r_row) * int'(IMG_DIM) + int'(r_col));
            end
            if (w_bad) begin
                r_err <= 1'b1;
            end
            unique case (r_state)
                StIdle: begin
                    if (w_en_on) r_state <= StLoadA;
                end
                StLoadA: begin
                    if (w_a_we) begin
                        if (r_a_cnt == AW'(NTAP - 1)) begin
                            r_a_cnt <= '0;
                            r_state <= StLoadX;
                        end else begin
                            r_a_cnt <= r_a_cnt + 1'b1;
                        end
                    end
                end
                StLoadX: begin
                    if (w_x_we) begin
                        if (r_x_cnt == XW'(NPIX - 1)) begin
                            r_x_cnt <= '0;
                            r_state <= StRun;
                        end else begin
                            r_x_cnt <= r_x_cnt + 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (r_kc != KW'(K - 1)) begin
                        r_kc <= r_kc + 1'b1;
                    end else begin
                        r_kc <= '0;
                        if (r_kr != KW'(K - 1)) begin
                            r_kr <= r_kr + 1'b1;
                        end else begin
                            r_kr <= '0;
                            if (r_col != CW'(IMG_DIM - 1)) begin
                                r_col <= r_col + 1'b1;
                            end else begin
                                r_col <= '0;
                                r_row <= w_pix_last ? '0 : r_row + 1'b1;
                                if (w_pix_last) r_state <= StDrain;
                            end
                        end
                    end
                end
                StDrain: begin
                    r_state  <= StDone;
                    r_finish <= 1'b1;
                end
                StDone: begin
                    if (w_a_we) begin
                        // Restart: this write already stored A[0]
                        r_a_cnt     <= AW'(1);
                        r_state     <= StLoadA;
                        r_finish    <= 1'b0;
                        r_res_raddr <= '0;
                    end else if (w_rd_res) begin
                        r_res_raddr <= (r_res_raddr == XW'(NPIX - 1)) ? '0 : r_res_raddr + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Output drive: strobes and issue addresses are combinational, the rest registered
    always_comb begin
        ready     = (wr_valid || rd_valid) && !w_stall;
        clk_en    = (r_state != StIdle);
        a_we      = w_a_we;
        x_we      = w_x_we;
        a_waddr   = r_a_cnt;
        x_waddr   = r_x_cnt;
        ld_data   = wdata[7:0];
        a_raddr   = w_run ? w_a_idx : '0;
        x_raddr   = w_run ? w_x_idx : '0;
        mac_valid = r_mac_valid;
        mac_first = r_mac_first;
        mac_last  = r_mac_last;
        mac_pad   = r_mac_pad;
        res_waddr = r_res_waddr;
        res_raddr = r_res_raddr;
        finish    = r_finish;
        err       = r_err;
        w_unused  = ^wdata[31:8];
    end

endmodule

// File: tb/tb_acc_conv_ctrl.sv
// Self-checking bench for acc_conv_ctrl: randomized load data and timing, with a tap-stream
// reference computed directly from the flat tap index.
module tb_acc_conv_ctrl;

    localparam int DIM   = 28;
    localparam int KK    = 3;
    localparam int NPIX  = DIM * DIM;
    localparam int NTAPS = NPIX * KK * KK;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        wr_valid = 1'b0;
    logic        rd_valid = 1'b0;
    logic [12:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ready, clk_en, a_we, x_we;
    logic [3:0]  a_waddr, a_raddr;
    logic [9:0]  x_waddr, x_raddr, res_waddr, res_raddr;
    logic [7:0]  ld_data;
    logic        mac_valid, mac_first, mac_last, mac_pad, finish, err;

    int checks = 0;
    int failures = 0;

    acc_conv_ctrl #(.IMG_DIM(DIM), .K(KK)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .wr_valid(wr_valid), .rd_valid(rd_valid),
        .addr(addr), .wdata(wdata), .ready(ready), .clk_en(clk_en), .a_we(a_we), .x_we(x_we),
        .a_waddr(a_waddr), .x_waddr(x_waddr), .ld_data(ld_data), .a_raddr(a_raddr),
        .x_raddr(x_raddr), .mac_valid(mac_valid), .mac_first(mac_first), .mac_last(mac_last),
        .mac_pad(mac_pad), .res_waddr(res_waddr), .res_raddr(res_raddr), .finish(finish),
        .err(err)
    );

    always #5 HCLK = ~HCLK;

    // Reference: tap t belongs to output pixel t/(K*K), tap index t%(K*K)
    function automatic void model_tap(input int t, output int tap, output bit pad, output int xr);
        int p, r, c, sr, sc;
        p   = t / (KK * KK);
        tap = t % (KK * KK);
        r   = p / DIM;
        c   = p % DIM;
        sr  = r + tap / KK - KK / 2;
        sc  = c + tap % KK - KK / 2;
        pad = (sr < 0) || (sr >= DIM) || (sc < 0) || (sc >= DIM);
        xr  = pad ? 0 : sr * DIM + sc;
    endfunction

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic start_write(input logic [12:0] a, input logic [31:0] d);
        wr_valid = 1'b1; rd_valid = 1'b0; addr = a; wdata = d;
        @(negedge HCLK);
    endtask

    task automatic start_read(input logic [12:0] a);
        rd_valid = 1'b1; wr_valid = 1'b0; addr = a;
        @(negedge HCLK);
    endtask

    task automatic end_access();
        @(posedge HCLK);
        #1;
        wr_valid = 1'b0; rd_valid = 1'b0;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        #23;
        checks++;
        if ({ready, clk_en, a_we, x_we, a_waddr, x_waddr, ld_data, a_raddr, x_raddr, mac_valid,
             mac_first, mac_last, mac_pad, res_waddr, res_raddr, finish, err} !== '0)
            begin failures++; $display("FAIL reset_outputs clk_en=%b finish=%b err=%b want all 0",
                                       clk_en, finish, err); end
        @(negedge HCLK);
        HRESETn = 1'b1;
        step();
    endtask

    task automatic test_idle_err();
        start_write(13'd1, $urandom);
        checks++;
        if ({ready, a_we} !== 2'b10) begin failures++;
            $display("FAIL idle_a_write ready=%b a_we=%b want 1 0", ready, a_we); end
        end_access();
        start_read(13'd3);
        end_access();
        @(negedge HCLK);
        checks++;
        if ({err, clk_en, res_raddr} !== {1'b1, 1'b0, 10'd0}) begin failures++;
            $display("FAIL idle_err err=%b clk_en=%b rptr=%0d want 1 0 0", err, clk_en, res_raddr); end
        step();
        start_write(13'd0, $urandom & 32'hFFFF_FFFE);
        end_access();
        @(negedge HCLK);
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL en0_clears_err err=%b want 0", err); end
        step();
    endtask

    task automatic test_enable();
        start_write(13'd0, $urandom | 32'h1);
        checks++;
        if ({ready, clk_en} !== 2'b10) begin failures++;
            $display("FAIL enable_cycle ready=%b clk_en=%b want 1 0", ready, clk_en); end
        end_access();
        @(negedge HCLK);
        checks++;
        if (clk_en !== 1'b1) begin failures++; $display("FAIL enable_clk_en got %b want 1", clk_en); end
        step();
    endtask

    task automatic test_load_a(input int start, input bit inject);
        for (int i = start; i < KK * KK; i++) begin
            logic [31:0] d;
            repeat ($urandom_range(0, 1)) step();
            if (inject && i == 4) begin
                start_write(13'd2, $urandom);
                checks++;
                if ({x_we, a_we} !== 2'b00) begin failures++;
                    $display("FAIL load_a_oop x_we=%b a_we=%b want 0 0", x_we, a_we); end
                end_access();
                @(negedge HCLK);
                checks++;
                if (err !== 1'b1) begin failures++; $display("FAIL load_a_oop_err got %b want 1", err); end
                step();
            end
            d = {$urandom_range(0, 32'hFF_FFFF), 8'(i + 1)};
            start_write(13'd1, d);
            checks++;
            if ({ready, a_we, x_we, a_waddr, ld_data} !== {1'b1, 1'b1, 1'b0, 4'(i), 8'(i + 1)})
                begin failures++; $display("FAIL load_a i=%0d ready=%b we=%b waddr=%0d data=%0d want 1 1 %0d %0d",
                                           i, ready, a_we, a_waddr, ld_data, i, i + 1); end
            end_access();
        end
    endtask

    task automatic test_load_x(input bit inject);
        for (int j = 0; j < NPIX; j++) begin
            logic [31:0] d;
            repeat ($urandom_range(0, 1)) step();
            if (inject && j == 100) begin
                start_write(13'd1, $urandom);
                checks++;
                if (a_we !== 1'b0) begin failures++; $display("FAIL load_x_oop a_we=%b want 0", a_we); end
                end_access();
                @(negedge HCLK);
                checks++;
                if (err !== 1'b1) begin failures++; $display("FAIL load_x_oop_err got %b want 1", err); end
                step();
            end
            d = $urandom;
            start_write(13'd2, d);
            checks++;
            if ({x_we, a_we, x_waddr, ld_data} !== {1'b1, 1'b0, 10'(j), d[7:0]}) begin failures++;
                $display("FAIL load_x j=%0d we=%b a_we=%b waddr=%0d want 1 0 %0d",
                         j, x_we, a_we, x_waddr, j); end
            end_access();
        end
    endtask

    // Entered at the first RUN cycle; leaves at DONE, one cycle after finish rises
    task automatic test_full_run();
        int n_valid = 0;
        int n_last = 0;
        logic [8:0] m00 = '0;
        logic [8:0] m2727 = '0;
        for (int n = 0; n <= NTAPS + 1; n++) begin
            int tap, xr, ptap, pxr;
            bit pad, ppad, e_valid, e_first, e_last, e_pad, e_fin;
            @(negedge HCLK);
            if (n < NTAPS) begin
                model_tap(n, tap, pad, xr);
                checks++;
                if ({a_raddr, x_raddr} !== {4'(tap), 10'(xr)}) begin failures++;
                    $display("FAIL run_issue n=%0d a=%0d x=%0d want %0d %0d",
                             n, a_raddr, x_raddr, tap, xr); end
            end
            e_valid = (n >= 1) && (n <= NTAPS);
            e_first = 1'b0; e_last = 1'b0; e_pad = 1'b0;
            if (e_valid) begin
                model_tap(n - 1, ptap, ppad, pxr);
                e_first = (ptap == 0);
                e_last  = (ptap == KK * KK - 1);
                e_pad   = ppad;
            end
            e_fin = (n > NTAPS);
            checks++;
            if ({clk_en, mac_valid, mac_first, mac_last, mac_pad, finish} !==
                {1'b1, e_valid, e_first, e_last, e_pad, e_fin}) begin failures++;
                $display("FAIL run_flags n=%0d en/v/f/l/p/fin=%b%b%b%b%b%b want %b%b%b%b%b%b", n,
                         clk_en, mac_valid, mac_first, mac_last, mac_pad, finish,
                         1'b1, e_valid, e_first, e_last, e_pad, e_fin); end
            if (e_last) begin
                checks++;
                if (res_waddr !== 10'((n - 1) / (KK * KK))) begin failures++;
                    $display("FAIL run_res_waddr n=%0d got %0d want %0d", n, res_waddr,
                             (n - 1) / (KK * KK)); end
            end
            if (n == 4) begin
                checks++;
                if (x_raddr !== 10'd0) begin failures++; $display("FAIL tap4_xraddr got %0d want 0", x_raddr); end
            end
            if (n == 8) begin
                checks++;
                if (x_raddr !== 10'd29) begin failures++; $display("FAIL tap8_xraddr got %0d want 29", x_raddr); end
            end
            if (mac_valid === 1'b1) n_valid++;
            if (mac_last === 1'b1) n_last++;
            if (n >= 1 && n <= 9) m00[n - 1] = mac_pad;
            if (n >= NTAPS - 8 && n <= NTAPS) m2727[n - (NTAPS - 8)] = mac_pad;
        end
        checks++;
        if (n_valid != NTAPS) begin failures++; $display("FAIL valid_count got %0d want %0d", n_valid, NTAPS); end
        checks++;
        if (n_last != NPIX) begin failures++; $display("FAIL last_count got %0d want %0d", n_last, NPIX); end
        checks++;
        if (m00 !== 9'h04F) begin failures++; $display("FAIL pad_mask_0_0 got %b want 001001111", m00); end
        checks++;
        if (m2727 !== 9'h1E4) begin failures++; $display("FAIL pad_mask_27_27 got %b want 111100100", m2727); end
        step();
    endtask

    task automatic test_results();
        @(negedge HCLK);
        checks++;
        if ({finish, res_raddr} !== {1'b1, 10'd0}) begin failures++;
            $display("FAIL done_entry finish=%b rptr=%0d want 1 0", finish, res_raddr); end
        step();
        for (int k = 1; k <= NPIX + 1; k++) begin
            start_read(13'd3);
            checks++;
            if (ready !== 1'b1) begin failures++; $display("FAIL read_ready k=%0d got %b want 1", k, ready); end
            end_access();
            if (k == NPIX) begin
                @(negedge HCLK);
                checks++;
                if (res_raddr !== 10'd0) begin failures++; $display("FAIL rptr_wrap got %0d want 0", res_raddr); end
                step();
            end
        end
        @(negedge HCLK);
        checks++;
        if (res_raddr !== 10'd1) begin failures++; $display("FAIL rptr_final got %0d want 1", res_raddr); end
        step();
    endtask

    task automatic test_restart();
        start_write(13'd1, 32'h0000_0101);
        checks++;
        if ({ready, a_we, a_waddr} !== {1'b1, 1'b1, 4'd0}) begin failures++;
            $display("FAIL restart_write ready=%b we=%b waddr=%0d want 1 1 0", ready, a_we, a_waddr); end
        end_access();
        start_read(13'd3);
        end_access();
        @(negedge HCLK);
        checks++;
        if ({finish, res_raddr, clk_en} !== {1'b0, 10'd0, 1'b1}) begin failures++;
            $display("FAIL restart_state finish=%b rptr=%0d clk_en=%b want 0 0 1",
                     finish, res_raddr, clk_en); end
        step();
    endtask

    // Addr-1 write issued mid-RUN must wait until DONE, then restart the load
    task automatic test_stall_until_done();
        int k = $urandom_range(0, 3000);
        int seen = -1;
        bit bad_we = 1'b0;
        for (int n = 0; n < 8000 && seen < 0; n++) begin
            if (n == k) begin wr_valid = 1'b1; addr = 13'd1; wdata = $urandom; end
            @(negedge HCLK);
            if (n >= k) begin
                if (ready === 1'b1) seen = n;
                else if (a_we !== 1'b0) bad_we = 1'b1;
            end
            if (seen < 0) step();
        end
        checks++;
        if (seen != NTAPS + 1) begin failures++; $display("FAIL stall_release got cycle %0d want %0d", seen, NTAPS + 1); end
        checks++;
        if (bad_we !== 1'b0) begin failures++; $display("FAIL stall_a_we got 1 want 0 while stalled"); end
        if (seen >= 0) begin
            checks++;
            if ({finish, a_we, a_waddr} !== {1'b1, 1'b1, 4'd0}) begin failures++;
                $display("FAIL stall_accept finish=%b we=%b waddr=%0d want 1 1 0", finish, a_we, a_waddr); end
        end
        end_access();
        @(negedge HCLK);
        checks++;
        if ({finish, clk_en} !== 2'b01) begin failures++;
            $display("FAIL stall_restart finish=%b clk_en=%b want 0 1", finish, clk_en); end
        step();
    endtask

    task automatic test_abort();
        bit stray = 1'b0;
        repeat ($urandom_range(20, 3000)) step();
        start_write(13'd0, 32'h0);
        checks++;
        if (ready !== 1'b1) begin failures++; $display("FAIL abort_ready got %b want 1", ready); end
        end_access();
        @(negedge HCLK);
        checks++;
        if ({mac_valid, clk_en, err, finish} !== 4'b0000) begin failures++;
            $display("FAIL abort_state valid=%b clk_en=%b err=%b finish=%b want 0000",
                     mac_valid, clk_en, err, finish); end
        for (int i = 0; i < 20; i++) begin
            step();
            @(negedge HCLK);
            if (mac_valid !== 1'b0 || mac_last !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray !== 1'b0) begin failures++; $display("FAIL abort_quiet got mac activity want none"); end
        step();
    endtask

    task automatic test_reset_mid_run();
        test_enable();
        test_load_a(0, 1'b0);
        test_load_x(1'b0);
        repeat ($urandom_range(5, 3000)) step();
        @(negedge HCLK);
        wdata = '0;
        #2;
        HRESETn = 1'b0;
        #1;
        checks++;
        if ({ready, clk_en, a_we, x_we, a_waddr, x_waddr, ld_data, a_raddr, x_raddr, mac_valid,
             mac_first, mac_last, mac_pad, res_waddr, res_raddr, finish, err} !== '0)
            begin failures++; $display("FAIL async_reset clk_en=%b valid=%b a=%0d x=%0d want all 0",
                                       clk_en, mac_valid, a_raddr, x_raddr); end
        @(negedge HCLK);
        HRESETn = 1'b1;
        step();
        test_enable();
        test_load_a(0, 1'b0);
        test_load_x(1'b0);
        test_full_run();
    endtask

    initial begin
        test_reset();
        test_idle_err();
        test_enable();
        test_load_a(0, 1'b1);
        test_load_x(1'b0);
        test_full_run();
        test_results();
        test_restart();
        test_load_a(1, 1'b0);
        test_load_x(1'b0);
        test_stall_until_done();
        test_load_a(1, 1'b0);
        test_load_x(1'b1);
        test_abort();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/acc_conv_ctrl.md
# acc_conv_ctrl

Sequencing controller for the 3x3-kernel / 28x28-image convolution accelerator. It sits between the APB slave front-end and the MAC datapath and its A, X and result memories. It decodes register writes, counts kernel (A) and image (X) loads, and gates the datapath clock. It then walks every output pixel and kernel tap with zero-padding flags, and hands results back through an auto-incrementing read pointer.

## Interface
- IMG_DIM, 28, image height and width; output is IMG_DIM x IMG_DIM (same padding)
- K, 3, kernel height and width (odd)
- Clocking and reset: one clock; reset is asynchronous and active-low.

Ports:
- HCLK  in  1  sole clock
- HRESETn  in  1  asynchronous active-low reset
- wr_valid  in  1  APB write access phase (PSEL&PENABLE&PWRITE)
- rd_valid  in  1  APB read access phase (PSEL&PENABLE&!PWRITE)
- addr  in  13  register address: 0 EN, 1 LOAD_A, 2 LOAD_X, 3 RESULT
- wdata  in  32  write data
- ready  out  1  PREADY source
- clk_en  out  1  datapath clock-gate enable
- a_we / x_we  out  1  A / X memory write strobes
- a_waddr  out  clog2(K*K)  A write address
- x_waddr  out  clog2(IMG_DIM^2)  X write address
- ld_data  out  8  = wdata[7:0], combinational
- a_raddr  out  clog2(K*K)  tap kernel read address (issue phase)
- x_raddr  out  clog2(IMG_DIM^2)  tap image read address (issue phase)
- mac_valid, mac_first, mac_last, mac_pad  out  1  tap qualifiers, aligned with 1-cycle memory read data
- res_waddr  out  clog2(IMG_DIM^2)  result write address, valid with mac_last
- res_raddr  out  clog2(IMG_DIM^2)  result read pointer
- finish  out  1  convolution complete
- err  out  1  sticky protocol error

## Operation
- States: IDLE, LOAD_A, LOAD_X, RUN, DRAIN, DONE.
- Write to EN with wdata[0]=1 in IDLE → LOAD_A. A write with wdata[0]=0 in any state → IDLE; all counters and pipeline flags are cleared. clk_en = (state != IDLE).
- LOAD_A: each accepted addr-1 write gives a_we=1 and a_waddr=a_cnt, then a_cnt increments. The K*K-th write → LOAD_X.
- LOAD_X: same scheme with x_cnt. The IMG_DIM^2-th write → RUN.
- Out-of-phase writes (addr 2 in LOAD_A; addr 1 in LOAD_X; addr 1/2 in IDLE) are accepted but ignored, and they set err.
- RUN issues one tap per cycle. Output order is row-major (r, c); taps are kr-major, kc-minor.
  - a_raddr = kr*K + kc.
  - Source pixel is (r+kr-K/2, c+kc-K/2). If it is outside the image, pad=1 and x_raddr=0.
  - first = tap 0; last = tap K*K-1.
  - Flags are registered one cycle, and res_waddr = r*IMG_DIM + c is registered alongside mac_last.
- After the final tap is issued: DRAIN (1 cycle) → DONE.
- DONE: finish=1. An addr-3 read increments res_raddr, which wraps from IMG_DIM^2-1 to 0. An addr-1 write restarts the sequence: it stores A[0], goes to LOAD_A with a_cnt=1, and clears finish and res_raddr.
- Addr-3 reads outside DONE do not increment. err clears only on EN=0 or reset.

## Timing
- Reset values: state IDLE; all outputs 0; all counters 0.
- ready = 0 for addr-1/2 writes during RUN and DRAIN (APB wait states). ready = 1 for every other access, including EN writes, so abort is always possible.
- Load strobes are combinational in the accepting cycle. Counter and state updates take effect at the next HCLK edge.
- The first RUN cycle is the cycle after the last X write is accepted. Taps are issued at RUN cycles t = 0 .. IMG_DIM^2*K*K-1 (7056 taps at defaults).
- mac_* are high at t+1. The final mac_last coincides with DRAIN. finish rises the following cycle, 7057 cycles after RUN entry at defaults.
- An EN=0 write during RUN: mac_valid is 0 from the next cycle, and no further res_waddr pulses occur.
- HRESETn low at any time: all state clears immediately (asynchronously).

## Test plan
- Reset, then EN=1 → clk_en=1, state LOAD_A. Write 9 A words 1..9 → a_waddr 0..8 with a_we each time; the 9th write moves the state to LOAD_X.
- Write 784 X words → x_waddr 0..783. Then mac_valid runs for 7056 consecutive cycles, finish is 1 at cycle 7057, and there are exactly 784 mac_last pulses with res_waddr 0..783 in order.
- Output (0,0) → taps 0,1,2,3,6 have mac_pad=1. Tap 4 has x_raddr=0; tap 8 has x_raddr=29. Output (27,27) → taps 2,5,6,7,8 are padded.
- Addr-1 write during RUN → ready stays 0 until DONE, then the write completes and the state goes to LOAD_A with a_cnt=1. 785 result reads → res_raddr ends at 1 (wrap).
- Addr-2 write in LOAD_A → err=1 and x_we=0. A mid-RUN EN=0 → mac_valid=0 next cycle, clk_en=0, err cleared.
- HRESETn pulsed low mid-RUN → all outputs 0 immediately. After release, a full second A/X load produces correct 784 results.
